// File: rtl/any1_pkg.sv
// Shared decode-stage types and constants for the any1 core front end.
package any1_pkg;

   localparam int DECQ_DEPTH = 8;
   localparam int DECQ_AW    = $clog2(DECQ_DEPTH);

   // Decode-queue pointer, exported so issue logic can track queue slots.
   typedef logic [DECQ_AW-1:0] decq_ptr_t;

   // Decoded instruction record produced by the decoder.
   typedef struct packed {
      logic [7:0]  rid;
      logic [31:0] ip;
      logic [31:0] ir;
      logic [1:0]  pip;
      logic [5:0]  Rt;
      logic [5:0]  Ra;
      logic [5:0]  Rb;
      logic [5:0]  Rc;
      logic [31:0] imm;
      logic        rfwr;
      logic        ui;
      logic [1:0]  Stream;
   } sDecode;

endpackage

// File: rtl/any1_decq_ram.sv
// Decode-queue storage: DEPTH x sDecode register file, one synchronous
// write port and one asynchronous read port (maps to distributed RAM).
module any1_decq_ram
   import any1_pkg::*;
#(
   parameter int DEPTH = DECQ_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  sDecode        wdata,
   input  logic [AW-1:0] raddr,
   output sDecode        rdata
);

   sDecode mem [DEPTH];

   // Write port; contents are intentionally not reset.
   always_ff @(posedge clk_i) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/any1_decode_queue.sv
// Decode queue: circular FIFO of sDecode records between decode and
// issue/rename, with valid/ready handshakes on both sides and a full flush.
// Optional macro ANY1_DECODE_QUEUE_BYPASS_EN forwards dec_i straight to
// iss_o when the queue is empty and issue is ready (zero latency).
module any1_decode_queue
   import any1_pkg::*;
#(
   parameter int DEPTH = DECQ_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic        dec_valid_i,
   input  sDecode      dec_i,
   output logic        dec_ready_o,
   output logic        iss_valid_o,
   output sDecode      iss_o,
   input  logic        iss_ready_i,
   output logic [AW:0] count_o,
   output logic        full_o,
   output logic        empty_o
);

   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   logic [AW-1:0] rd_ptr_reg;
   logic [AW-1:0] wr_ptr_reg;
   logic [AW:0]   count_reg;
   logic          enq;
   logic          deq;
   logic          bypass;
   sDecode        ram_rd;

   assign count_o = count_reg;
   assign empty_o = (count_reg == '0);
   assign full_o  = (count_reg == DEPTH_CNT);

`ifdef ANY1_DECODE_QUEUE_BYPASS_EN
   // Empty queue with both sides ready: hand the record straight through.
   assign bypass = empty_o & dec_valid_i & iss_ready_i & ~flush_i;
`else
   assign bypass = 1'b0;
`endif

   assign iss_valid_o = ~empty_o | bypass;
   // A same-cycle dequeue frees a slot even when full.
   assign dec_ready_o = ~full_o | (iss_ready_i & iss_valid_o);
   // Bypassed records never touch storage.
   assign enq = dec_valid_i & dec_ready_o & ~flush_i & ~bypass;
   assign deq = ~empty_o & iss_ready_i & ~flush_i;

   any1_decq_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk_i (clk_i),
      .we    (enq),
      .waddr (wr_ptr_reg),
      .wdata (dec_i),
      .raddr (rd_ptr_reg),
      .rdata (ram_rd)
   );

   // Output mux: head entry, bypassed record, or zero when nothing valid.
   always_comb begin
      iss_o = '0;
      if (bypass) begin
         iss_o = dec_i;
      end else if (!empty_o) begin
         iss_o = ram_rd;
      end
   end

   // Pointer and occupancy update; flush outranks enqueue/dequeue.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush_i) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (enq) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (deq) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({enq, deq})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

`ifndef SYNTHESIS
   logic [$bits(dec_i.rid)-1:0] rid_shadow [DEPTH];

   // Shadow copy of enqueued rids used to confirm FIFO ordering.
   always_ff @(posedge clk_i) begin
      if (enq) begin
         rid_shadow[wr_ptr_reg] <= dec_i.rid;
      end
   end

   // Simulation-only sanity checks on occupancy and ordering.
   always @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(enq && full_o && !deq))
            else $error("enqueue into full queue without dequeue");
         assert (count_reg <= DEPTH_CNT)
            else $error("count exceeds depth");
         if (deq) begin
            assert (iss_o.rid == rid_shadow[rd_ptr_reg])
               else $error("dequeue order differs from enqueue order");
         end
      end
   end
`endif

endmodule
